// File: rtl/seg_scan_driver_pkg.sv
// seg_pkg: shared types and active-low segment codes for the scan driver.
// Codes are ordered {g,f,e,d,c,b,a}; a cleared bit lights the segment.
package seg_pkg;

  typedef logic [3:0] digit_t;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'b1111;

endpackage

// File: rtl/seg_scan_driver_if.sv
// seg_scan_if: phase/load inputs and display outputs of the scan driver.
// master = upstream/host side, slave = seg_scan_driver.
interface seg_scan_if;
  logic [1:0]  count;
  logic        load;
  logic [15:0] value;
  logic        pending;
  logic        frame_done;
  logic [3:0]  an;
  logic [6:0]  seg;

  modport master (
    output count, load, value,
    input  pending, frame_done, an, seg
  );

  modport slave (
    input  count, load, value,
    output pending, frame_done, an, seg
  );
endinterface

// File: rtl/seg_scan_driver_hex_to_seg.sv
// hex_to_seg: combinational hex digit to active-low 7-segment decoder.
// Ports: d (4-bit digit in), seg (7-bit {g..a} out).
module hex_to_seg
  import seg_pkg::*;
(
  input  digit_t     d,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    unique case (d)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: 4-digit 7-seg scanner, frame-synchronous value commit.
// Ports: clk, reset (async high), bus (seg_scan_if.slave). SEG_SCAN_LZB_EN.
module seg_scan_driver
  import seg_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  seg_scan_if.slave bus
);

  logic [15:0] staging;
  logic [15:0] shadow;
  logic [15:0] shadow_nx;
  logic [1:0]  prev_count;
  logic        pend_q;
  logic        fd_q;
  logic [3:0]  an_q;
  logic [6:0]  seg_q;
  logic        wrap;
  logic        blank;
  digit_t      digit;
  logic [6:0]  dec;

  assign wrap = (prev_count == 2'd3)
             && (bus.count == 2'd0);

  // Display path looks at the value that will
  // be shown after this edge, so a commit shows
  // up on digit 0 in the very next cycle.
  always_comb begin
    shadow_nx = shadow;
    if (wrap) begin
      if (bus.load)
        shadow_nx = bus.value;
      else if (pend_q)
        shadow_nx = staging;
    end
  end

  assign digit = shadow_nx[{bus.count, 2'b00} +: 4];

  hex_to_seg u_dec (
    .d   (digit),
    .seg (dec)
  );

`ifdef SEG_SCAN_LZB_EN
  always_comb begin
    blank = 1'b0;
    unique case (bus.count)
      2'd0: blank = 1'b0;
      2'd1: blank = (shadow_nx[15:4]  == 12'd0);
      2'd2: blank = (shadow_nx[15:8]  == 8'd0);
      2'd3: blank = (shadow_nx[15:12] == 4'd0);
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      staging    <= '0;
      shadow     <= '0;
      prev_count <= '0;
      pend_q     <= 1'b0;
      fd_q       <= 1'b0;
      an_q       <= AN_OFF;
      seg_q      <= SEG_BLANK;
    end else begin
      prev_count <= bus.count;
      fd_q       <= wrap;
      shadow     <= shadow_nx;
      if (bus.load)
        staging <= bus.value;
      if (wrap)
        pend_q <= 1'b0;
      else if (bus.load)
        pend_q <= 1'b1;
      if (blank) begin
        an_q  <= AN_OFF;
        seg_q <= SEG_BLANK;
      end else begin
        an_q  <= ~(4'b0001 << bus.count);
        seg_q <= dec;
      end
    end
  end

  assign bus.pending    = pend_q;
  assign bus.frame_done = fd_q;
  assign bus.an         = an_q;
  assign bus.seg        = seg_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed + random stimulus vs a frame-level model.
// Build with SEG_SCAN_LZB_EN defined to exercise leading-zero blanking.
module tb_seg_scan_driver;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  seg_scan_if bus ();

  seg_scan_driver dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Display glyphs, gfedcba active-low, written out per hex digit.
  logic [6:0] glyph [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Model: what the user sees and what is queued for the next frame.
  int unsigned m_shown;
  int unsigned m_queued;
  bit          m_has_q;
  int          m_last_ph;
  bit          m_fd;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_shown   = 0;
    m_queued  = 0;
    m_has_q   = 0;
    m_last_ph = 0;
    m_fd      = 0;
  endtask

  // Called at a negedge: drive inputs, advance the model, check after edge.
  task automatic step(input int ph, input bit ld,
                      input logic [15:0] v);
    bit          frame;
    int unsigned upper;
    bit          blank;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    bus.count = ph[1:0];
    bus.load  = ld;
    bus.value = v;
    frame = (m_last_ph == 3) && (ph == 0);
    if (frame) begin
      if (ld) m_shown = v;
      else if (m_has_q) m_shown = m_queued;
      m_has_q = 0;
    end else if (ld) begin
      m_has_q = 1;
    end
    if (ld) m_queued = v;
    m_last_ph = ph;
    m_fd = frame;
    upper = m_shown / (16 ** ph);
    blank = 0;
`ifdef SEG_SCAN_LZB_EN
    blank = (ph != 0) && (upper == 0);
`endif
    e_an  = blank ? 4'hF : 4'(15 - (2 ** ph));
    e_seg = blank ? 7'h7F : glyph[upper % 16];
    @(posedge clk);
    #1;
    check("an", 32'(bus.an), 32'(e_an));
    check("seg", 32'(bus.seg), 32'(e_seg));
    check("pending", 32'(bus.pending), 32'(m_has_q));
    check("frame_done", 32'(bus.frame_done), 32'(m_fd));
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.count = 2'd0;
    bus.load  = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_an", 32'(bus.an), 32'hF);
    check("rst_seg", 32'(bus.seg), 32'h7F);
    check("rst_pend", 32'(bus.pending), 32'h0);
    check("rst_fd", 32'(bus.frame_done), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic frame(input int n);
    for (int f = 0; f < n; f++)
      for (int p = 0; p < 4; p++)
        step(p, 1'b0, 16'h0);
  endtask

  initial begin
    int ph;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.count = 2'd0;
    bus.load  = 1'b0;
    bus.value = 16'h0;
    model_reset();
    repeat (3) @(negedge clk);
    check("init_an", 32'(bus.an), 32'hF);
    check("init_seg", 32'(bus.seg), 32'h7F);
    check("init_pend", 32'(bus.pending), 32'h0);
    reset = 1'b0;

    frame(2);

    // load at phase 1, commit on the next wrap
    step(0, 1'b0, 16'h0);
    step(1, 1'b1, 16'h1234);
    step(2, 1'b0, 16'h0);
    step(3, 1'b0, 16'h0);
    frame(2);

    // last load in a frame wins
    step(0, 1'b1, 16'hAAAA);
    step(1, 1'b0, 16'h0);
    step(2, 1'b1, 16'h00F5);
    step(3, 1'b0, 16'h0);
    frame(2);

    // load exactly on the wrap cycle
    step(0, 1'b0, 16'h0);
    step(1, 1'b0, 16'h0);
    step(2, 1'b0, 16'h0);
    step(3, 1'b0, 16'h0);
    step(0, 1'b1, 16'h8888);
    step(1, 1'b0, 16'h0);
    step(2, 1'b0, 16'h0);
    step(3, 1'b0, 16'h0);
    frame(1);

    // upstream counter held in reset mid-frame
    step(0, 1'b0, 16'h0);
    step(1, 1'b1, 16'h5A3C);
    step(0, 1'b0, 16'h0);
    step(0, 1'b0, 16'h0);
    step(0, 1'b0, 16'h0);
    frame(2);

    // blanking pattern (plain digits when the feature is off)
    step(0, 1'b1, 16'h0007);
    step(1, 1'b0, 16'h0);
    step(2, 1'b0, 16'h0);
    step(3, 1'b0, 16'h0);
    frame(2);

    // reset mid-frame with a load pending
    step(0, 1'b0, 16'h0);
    step(1, 1'b1, 16'hBEEF);
    do_reset();
    frame(2);

    // random phase behaviour and loads
    ph = 0;
    for (int i = 0; i < 600; i++) begin
      int r;
      bit ld;
      logic [15:0] v;
      r = int'($urandom_range(0, 99));
      if (r < 70) ph = (ph + 1) % 4;
      else if (r < 85) ph = ph;
      else ph = 0;
      ld = ($urandom_range(0, 4) == 0);
      v  = 16'($urandom);
      if ($urandom_range(0, 2) == 0)
        v = v >> (4 * $urandom_range(1, 3));
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
        ph = 0;
      end else begin
        step(ph, ld, v);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Four-digit, seven-segment scan driver that sits directly downstream of the 2-bit free-running `counter`, using its `count` output as the digit-select phase. It holds a 16-bit hex value, commits new values only at frame boundaries (count wrap 3→0) to prevent tearing, and drives registered, active-low anode and segment outputs.

## Interface
- No parameters; width fixed at 4 digits × 4 bits.
- `clk` input 1: system clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `count` input 2: digit phase from the upstream counter (0..3).
- `load` input 1: single-cycle strobe that captures `value`.
- `value` input 16: hex value to display; digit n is `value[4n+3:4n]`.
- `pending` output 1: a loaded value is waiting for the next frame boundary.
- `frame_done` output 1: one-cycle pulse on each detected 3→0 wrap.
- `an` output 4: digit enables, active-low; bit n enables digit n.
- `seg` output 7: segments {g,f,e,d,c,b,a}, active-low.

## Operation
- Internal registers: `staging[15:0]`, `shadow[15:0]` (displayed value), `prev_count[1:0]`, `pending`.
- Wrap event: `prev_count == 3 && count == 0`. `prev_count <= count` every cycle.
- Load only: `staging <= value`, `pending <= 1`.
- Load while `pending == 1`: `staging` is overwritten; `pending` stays 1 (last value wins).
- Wrap with `pending == 1` and no load: `shadow <= staging`, `pending <= 0`.
- Load and wrap in the same cycle: `shadow <= value` directly; `pending <= 0`; `staging <= value`.
- Wrap with `pending == 0` and no load: `shadow` unchanged.
- Display: for phase k = `count`, `an` drives only bit k low (k=0 → 4'b1110, k=3 → 4'b0111); `seg` = hex-to-segment encoding of `shadow` digit k (0→7'b1000000, 8→7'b0000000, F→7'b0001110).
- `count` may stall (the upstream counter is held in reset). Outputs then follow the held phase; no wrap is detected until a real 3→0 transition occurs.

## Timing
- Reset values: `an = 4'b1111`, `seg = 7'h7F`, `pending = 0`, `frame_done = 0`, `shadow = 0`, `staging = 0`, `prev_count = 0`.
- `an` and `seg` are registered, with 1-cycle latency from `count` to output.
- `pending` rises in the cycle after `load`.
- A committed `shadow` value appears on `seg` in the cycle after the wrap, at digit 0.
- `frame_done` is asserted in the cycle after the wrap and lasts exactly 1 cycle.
- Reset mid-frame clears the pending load and blanks the display immediately (asynchronous). The first wrap needs an observed 3 after reset.

## Configuration
- `SEG_SCAN_LZB_EN` (leading-zero blanking).
  - Defined: digit k ≥ 1 is blanked when that digit and all higher digits of `shadow` are zero. Blanking forces `an` bit k to 1 and `seg` to 7'h7F. Digit 0 is never blanked.
  - Undefined: all four digits are always driven.

## Structure
- Package `seg_pkg`:
  - Segment-code constants for 0..F.
  - `SEG_BLANK = 7'h7F`.
  - `AN_OFF = 4'b1111`.
  - A `digit_t` typedef (4-bit).
- Sub-module `hex_to_seg`: combinational 4-bit → 7-bit active-low decoder, instantiated once on the selected digit.

## Test plan
- Reset held 30 ns, then free-running `count` with `shadow = 0` → after reset `an = 1111` and `seg = 7F`; afterwards `an` cycles 1110, 1101, 1011, 0111 with `seg = 7'b1000000` each phase.
- `load` with `value = 16'h1234` at count = 1 → `pending = 1` until the wrap; from the next digit-0 phase `seg` shows 4, 3, 2, 1; `frame_done` is a 1-cycle pulse.
- Two loads in one frame (`16'hAAAA` then `16'h00F5`) → only `16'h00F5` is displayed after the wrap.
- `load` with `value = 16'h8888` in the exact wrap cycle → `pending` stays 0, and `seg = 7'b0000000` from the next cycle.
- Upstream counter reset asserted for 20 ns mid-frame (count held at 0) → no `frame_done`; a pending load remains pending until the next 3→0 transition.
- With `SEG_SCAN_LZB_EN` defined and `value = 16'h0007` → digits 1–3 are blanked (`an` stays 1111 in those phases); digit 0 shows `seg = 7'b1111000`.
